// File: rtl/idx_merge_sched.sv
// idx_merge_sched: merges varint and raw source heads into one output FIFO in ascending field-index order.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   start, frame_len            one-cycle frame start and item count (sampled in IDLE/ERROR)
//   out_fifo_full               FIFO backpressure
//   out_fifo_clr/push/data      FIFO clear strobe, write strobe and write data
//   varint_valid/index/data     varint head item; varint_accepted pops it
//   raw_valid/index/data        raw head item; raw_accepted pops it
//   busy, done                  frame in progress, one-cycle frame-complete pulse
//   err_timeout, err_collision  sticky stall and same-index errors, cleared by the next start
module idx_merge_sched #(
    parameter int IDX_W   = 10,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  frame_len,
    input  logic              out_fifo_full,
    output logic              out_fifo_clr,
    output logic              out_fifo_push,
    output logic [DATA_W-1:0] out_fifo_data,
    input  logic              varint_valid,
    input  logic [IDX_W-1:0]  varint_index,
    input  logic [DATA_W-1:0] varint_data,
    output logic              varint_accepted,
    input  logic              raw_valid,
    input  logic [IDX_W-1:0]  raw_index,
    input  logic [DATA_W-1:0] raw_data,
    output logic              raw_accepted,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_collision
);
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        CLEAR = 6'b000010,
        WAIT  = 6'b000100,
        PUSH  = 6'b001000,
        DONE  = 6'b010000,
        ERROR = 6'b100000
    } state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] index, index_n, len, len_n, index_inc;
    logic [TO_W-1:0] stall, stall_n;
    logic [DATA_W-1:0] data_n;
    logic v_hit, r_hit, et_n, ec_n;
    assign v_hit = varint_valid && varint_index == index;
    assign r_hit = raw_valid && raw_index == index;
    assign index_inc = index + 1'b1;
    always_comb begin
        state_n = state;
        index_n = index;
        len_n = len;
        stall_n = stall;
        data_n = out_fifo_data;
        et_n = err_timeout;
        ec_n = err_collision;
        unique case (state)
            IDLE: begin
                if (start) begin
                    len_n = frame_len;
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                index_n = '0;
                stall_n = '0;
                state_n = len == '0 ? DONE : WAIT;
            end
            WAIT: begin
                if (v_hit && r_hit) begin
                    ec_n = 1'b1;
                    state_n = ERROR;
                end else if (v_hit || r_hit) begin
                    stall_n = '0;
                    if (!out_fifo_full) begin
                        data_n = r_hit ? raw_data : varint_data;
                        state_n = PUSH;
                    end
                end else if (TIMEOUT != 0 && stall == TO_W'(TIMEOUT - 1)) begin
                    et_n = 1'b1;
                    state_n = ERROR;
                end else begin
                    stall_n = stall + 1'b1;
                end
            end
            PUSH: begin
                index_n = index_inc;
                stall_n = '0;
                state_n = index_inc == len ? DONE : WAIT;
            end
            DONE: state_n = IDLE;
            ERROR: begin
                if (start) begin
                    et_n = 1'b0;
                    ec_n = 1'b0;
                    len_n = frame_len;
                    state_n = CLEAR;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state, so each strobe lines up with its state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            len <= '0;
            stall <= '0;
            out_fifo_clr <= 1'b0;
            out_fifo_push <= 1'b0;
            out_fifo_data <= '0;
            varint_accepted <= 1'b0;
            raw_accepted <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err_timeout <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            state <= state_n;
            index <= index_n;
            len <= len_n;
            stall <= stall_n;
            out_fifo_clr <= state_n == CLEAR;
            out_fifo_push <= state_n == PUSH;
            out_fifo_data <= data_n;
            varint_accepted <= state_n == PUSH && !r_hit;
            raw_accepted <= state_n == PUSH && r_hit;
            busy <= state_n inside {CLEAR, WAIT, PUSH};
            done <= state_n == DONE;
            err_timeout <= et_n;
            err_collision <= ec_n;
        end
    end
endmodule

// File: doc/idx_merge_sched.md
Name: idx_merge_sched

Overview:
- Index-ordered merge scheduler that shares one output FIFO between the varint encoder and the raw-data path.
- Per frame: clears the FIFO, then pushes items strictly in ascending field-index order 0..frame_len-1, each from whichever source presents the current index at its head.
- Handles start/done sequencing, FIFO-full backpressure, source accept handshakes, and index-collision and stall-timeout detection.

Parameters:
IDX_W, 10, width of field index, frame_len and internal index counter
DATA_W, 8, width of source data and FIFO write data
TIMEOUT, 1024, WAIT cycles with no hit before err_timeout; 0 disables the timeout
TO_W, 11, width of stall counter; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a frame (honoured in IDLE and ERROR only)
frame_len  in  IDX_W  item count for the frame; sampled when start is honoured
out_fifo_full  in  1  output FIFO full
out_fifo_clr  out  1  one-cycle FIFO clear
out_fifo_push  out  1  one-cycle FIFO write strobe
out_fifo_data  out  DATA_W  FIFO write data, valid with push
varint_valid  in  1  varint head item present
varint_index  in  IDX_W  field index of varint head
varint_data  in  DATA_W  varint head data
varint_accepted  out  1  one-cycle pop of varint head
raw_valid  in  1  raw head item present
raw_index  in  IDX_W  field index of raw head
raw_data  in  DATA_W  raw head data
raw_accepted  out  1  one-cycle pop of raw head
busy  out  1  high in CLEAR, WAIT, PUSH
done  out  1  one-cycle frame-complete pulse
err_timeout  out  1  sticky stall error
err_collision  out  1  sticky both-sources-same-index error

Behaviour:
- All outputs registered. On reset: state IDLE; index, stall counter, len register and all outputs 0. Reset mid-frame aborts without a clr pulse; FIFO contents are untouched.
- States: IDLE, CLEAR, WAIT, PUSH, DONE, ERROR (one-hot).
- IDLE
  - start=1: latch frame_len, go to CLEAR. Otherwise stay.
- CLEAR (1 cycle)
  - out_fifo_clr=1; index<=0; stall<=0.
  - Next: DONE if len==0, else WAIT.
- WAIT
  - v_hit = varint_valid & (varint_index==index); r_hit = raw_valid & (raw_index==index).
  - v_hit & r_hit: go to ERROR, set err_collision. No accept, no push.
  - Exactly one hit and !out_fifo_full: latch that source's data and select into holding regs, go to PUSH.
  - Hit while full: stay; stall<=0. Backpressure never times out.
  - No hit: stall<=stall+1. If TIMEOUT!=0 and stall==TIMEOUT-1: go to ERROR, set err_timeout.
- PUSH (1 cycle)
  - out_fifo_push=1; out_fifo_data=held data; the selected source's accepted=1 and the other's stays 0.
  - index<=index+1; stall<=0.
  - Next: DONE if index+1==len, else WAIT.
- Timing: hit seen in WAIT at cycle N; push and accept at N+1; next comparison at N+2. Peak throughput is 1 item per 2 cycles.
- A source may hold valid across the accept cycle. The incremented index prevents a stale head from re-matching.
- DONE (1 cycle): done=1, go to IDLE.
- ERROR
  - busy=0; error flags held.
  - start=1: clear both flags, latch frame_len, go to CLEAR.
- start in CLEAR, WAIT, PUSH or DONE is ignored.
- Source indices outside 0..len-1 simply never hit; they lead to timeout if no valid hit arrives.
- The index never wraps: a frame ends at len <= 2^IDX_W-1.

Test Plan:
- Interleave, frame_len=4: raw heads 0,2 and varint heads 1,3 always valid, FIFO never full -> clr 1 cycle after start; pushes raw0,var1,raw2,var3 on alternating cycles; done exactly 1 cycle after the 4th push; each accepted pulses once per item.
- Backpressure: full=1 for 20 cycles while varint head is index 0, TIMEOUT=8 -> no push, no err_timeout; push one cycle after the first WAIT cycle with full=0.
- Collision: varint_index=raw_index=0, both valid, after start -> err_collision=1; no push, no accepts; next start clears the flag and pulses clr.
- Timeout, TIMEOUT=8: no valid source after CLEAR -> err_timeout asserted on the cycle after the 8th WAIT cycle; busy=0.
- frame_len=0 -> clr pulse then done the next cycle; no push.
- Reset asserted in WAIT with index=2 -> next cycle all outputs 0, state IDLE; a later start with frame_len=1 completes normally with index restarting at 0.
